// File: rtl/dct_pkg.sv
// Shared state encoding, fixed-point cosine constants and the saturation helper
// for the streaming 2-D DCT.
package dct_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ROW, COL, OUT} state_t;

  // cos(k*pi/16) held as round(cos*2^30); Ck = round(0.5*cos*2^frac).
  function automatic int dct_coef(input int k, input int frac);
    longint c30;
    case (k)
      1:       c30 = 64'sd1053110176;
      2:       c30 = 64'sd992008095;
      3:       c30 = 64'sd892783698;
      4:       c30 = 64'sd759250125;
      5:       c30 = 64'sd596538996;
      6:       c30 = 64'sd410903207;
      7:       c30 = 64'sd209476638;
      default: c30 = 64'sd0;
    endcase
    return int'((c30 * (64'sd1 <<< frac) + (64'sd1 <<< 30)) >>> 31);
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/dct1d_8pt.sv
// Combinational 8-point forward DCT butterfly. With DCT_ROUND_EN defined every
// FRAC shift rounds half up; otherwise it floors.
module dct1d_8pt
  import dct_pkg::*;
#(
  parameter int FRAC  = 10,
  parameter int ACC_W = 32
) (
  input  logic signed [ACC_W-1:0] i_x [8],
  output logic signed [ACC_W-1:0] o_y [8]
);

  localparam logic signed [ACC_W-1:0] C1 = ACC_W'(dct_coef(1, FRAC));
  localparam logic signed [ACC_W-1:0] C2 = ACC_W'(dct_coef(2, FRAC));
  localparam logic signed [ACC_W-1:0] C3 = ACC_W'(dct_coef(3, FRAC));
  localparam logic signed [ACC_W-1:0] C4 = ACC_W'(dct_coef(4, FRAC));
  localparam logic signed [ACC_W-1:0] C5 = ACC_W'(dct_coef(5, FRAC));
  localparam logic signed [ACC_W-1:0] C6 = ACC_W'(dct_coef(6, FRAC));
  localparam logic signed [ACC_W-1:0] C7 = ACC_W'(dct_coef(7, FRAC));
`ifdef DCT_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'sd1 <<< (FRAC - 1));
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  logic signed [ACC_W-1:0] w_s [4];
  logic signed [ACC_W-1:0] w_d [4];
  logic signed [ACC_W-1:0] w_p [8];

  function automatic logic signed [ACC_W-1:0] fshift(input logic signed [ACC_W-1:0] v);
    return (v + RND) >>> FRAC;
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_s[k] = i_x[k] + i_x[7-k];
      w_d[k] = i_x[k] - i_x[7-k];
    end
    w_p[0] = C4 * (w_s[0] + w_s[1] + w_s[2] + w_s[3]);
    w_p[4] = C4 * (w_s[0] - w_s[1] - w_s[2] + w_s[3]);
    w_p[2] = C2 * (w_s[0] - w_s[3]) + C6 * (w_s[1] - w_s[2]);
    w_p[6] = C6 * (w_s[0] - w_s[3]) + C2 * (w_s[2] - w_s[1]);
    w_p[1] = C1 * w_d[0] + C3 * w_d[1] + C5 * w_d[2] + C7 * w_d[3];
    w_p[3] = C3 * w_d[0] - C7 * w_d[1] - C1 * w_d[2] - C5 * w_d[3];
    w_p[5] = C5 * w_d[0] - C1 * w_d[1] + C7 * w_d[2] + C3 * w_d[3];
    w_p[7] = C7 * w_d[0] - C5 * w_d[1] + C3 * w_d[2] - C1 * w_d[3];
    for (int k = 0; k < 8; k++) o_y[k] = fshift(w_p[k]);
  end

endmodule

// File: rtl/dct2d_stream.sv
// Streaming 8x8 forward 2-D DCT: rows in, ROW and COL passes through one shared
// 1-D core over an in-place buffer, coefficient rows out. DCT_ROUND_EN selects rounding.
module dct2d_stream
  import dct_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int FRAC  = 10,
  parameter int OUT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*PIX_W-1:0]   in_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   out_row,
  output logic                 out_last,
  output logic                 busy
);

  // state | meaning
  // IDLE  | single cycle after reset
  // LOAD  | accept 8 pixel rows into buffer rows 0..7
  // ROW   | transform buffer row cnt, level-shifted, written back in place
  // COL   | transform buffer column cnt, saturated, written back in place
  // OUT   | present buffer row cnt until the consumer takes it

  localparam logic signed [ACC_W-1:0] LVL = ACC_W'(64'sd1 <<< (PIX_W - 1));

  state_t r_state;
  state_t w_next;
  logic [2:0] r_cnt;
  logic signed [ACC_W-1:0] r_buf [8][8];
  logic signed [ACC_W-1:0] w_core_x [8];
  logic signed [ACC_W-1:0] w_core_y [8];
  logic signed [ACC_W-1:0] w_col_y [8];
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_cnt_last;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign w_cnt_last = (r_cnt == 3'd7);

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = LOAD;
      LOAD:    if (w_in_xfer && w_cnt_last) w_next = ROW;
      ROW:     if (w_cnt_last) w_next = COL;
      COL:     if (w_cnt_last) w_next = OUT;
      OUT:     if (w_out_xfer && w_cnt_last) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_row   = '0;
    case (r_state)
      LOAD:     in_ready = 1'b1;
      ROW, COL: busy = 1'b1;
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = w_cnt_last;
        for (int j = 0; j < 8; j++) out_row[j*OUT_W +: OUT_W] = r_buf[r_cnt][j][OUT_W-1:0];
      end
      default: ;
    endcase
  end

  // One counter serves row index in LOAD/ROW/OUT and column index in COL.
  always_ff @(posedge Clk) begin
    if (Reset) r_cnt <= '0;
    else if (w_in_xfer || w_out_xfer || r_state == ROW || r_state == COL) r_cnt <= r_cnt + 3'd1;
  end

  always_comb begin
    for (int j = 0; j < 8; j++) w_core_x[j] = '0;
    if (r_state == ROW) begin
      for (int j = 0; j < 8; j++) w_core_x[j] = r_buf[r_cnt][j] - LVL;
    end else if (r_state == COL) begin
      for (int j = 0; j < 8; j++) w_core_x[j] = r_buf[j][r_cnt];
    end
    for (int j = 0; j < 8; j++) w_col_y[j] = ACC_W'(saturate(64'(w_core_y[j]), OUT_W));
  end

  always_ff @(posedge Clk) begin
    if (w_in_xfer) begin
      for (int j = 0; j < 8; j++) r_buf[r_cnt][j] <= {{(ACC_W-PIX_W){1'b0}}, in_row[j*PIX_W +: PIX_W]};
    end else if (r_state == ROW) begin
      for (int j = 0; j < 8; j++) r_buf[r_cnt][j] <= w_core_y[j];
    end else if (r_state == COL) begin
      for (int j = 0; j < 8; j++) r_buf[j][r_cnt] <= w_col_y[j];
    end
  end

  dct1d_8pt #(.FRAC(FRAC), .ACC_W(ACC_W)) u_core (
    .i_x (w_core_x),
    .o_y (w_core_y)
  );

endmodule

// File: tb/tb_dct2d_stream.sv
// Scoreboard bench for dct2d_stream: a cosine-matrix reference model predicts each
// output row (16-bit and 10-bit saturating instances), honouring DCT_ROUND_EN.
module tb_dct2d_stream;

  logic Clk = 1'b0;
  logic Reset, in_valid, out_ready;
  logic in_ready, out_valid, out_last, busy;
  logic [63:0] in_row;
  logic [127:0] out_row;
  logic in_ready_s, out_valid_s, out_last_s, busy_s;
  logic [79:0] out_row_s;

  int total = 0;
  int bad = 0;
  int pix [8][8];
  int M [8][8];
  logic [127:0] q16 [$];
  logic [79:0] q10 [$];
  logic qlast [$];
  logic [127:0] got [8];
  logic [79:0] got_s [8];

  always #5 Clk = ~Clk;

  dct2d_stream dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last), .busy(busy)
  );

  dct2d_stream #(.OUT_W(10)) dut_s (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_s), .in_row(in_row),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_row(out_row_s), .out_last(out_last_s), .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic longint fsh(input longint v);
`ifdef DCT_ROUND_EN
    return (v + 64'sd512) >>> 10;
`else
    return v >>> 10;
`endif
  endfunction

  function automatic longint clampw(input longint v, input int w);
    longint hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 1;
    lo = -(64'sd1 <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic build_matrix();
    real pi, ang;
    pi = 3.14159265358979;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        ang = (k == 0) ? pi / 4.0 : real'((2 * n + 1) * k) * pi / 16.0;
        M[k][n] = int'($floor(0.5 * $cos(ang) * 1024.0 + 0.5));
      end
  endtask

  task automatic push_expected();
    longint t [8][8];
    longint acc, y;
    logic [127:0] r16;
    logic [79:0] r10;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++) acc += longint'(pix[r][n] - 128) * M[k][n];
        t[r][k] = fsh(acc);
      end
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 8; c++) begin
        acc = 0;
        for (int r = 0; r < 8; r++) acc += t[r][c] * M[k][r];
        y = fsh(acc);
        r16[c*16 +: 16] = 16'(clampw(y, 16));
        r10[c*10 +: 10] = 10'(clampw(y, 10));
      end
      q16.push_back(r16);
      q10.push_back(r10);
      qlast.push_back(k == 7);
    end
  endtask

  task automatic fill_const(input int v);
    for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) pix[r][j] = v;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++) for (int j = 0; j < 8; j++) pix[r][j] = int'($urandom_range(0, 255));
  endtask

  function automatic logic [63:0] pack_row(input int r);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[j*8 +: 8] = 8'(pix[r][j]);
    return v;
  endfunction

  task automatic send_block(input bit keep_valid);
    int n;
    push_expected();
    for (int r = 0; r < 8; r++) begin
      in_valid = 1'b1;
      in_row = pack_row(r);
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin step(); n++; end
      if (n >= 100) chk_i("in_ready_timeout", n, 0);
      step();
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic collect(input int stall_row, input bit chk_lat, input bit chk_b2b);
    int lat, n;
    bit leak, stable;
    logic [127:0] held;
    lat = 1;
    leak = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) leak = 1;
      step();
      lat++;
    end
    if (chk_lat) chk_i("latency", lat, 17);
    chk_i("in_ready_low_compute", int'(leak), 0);
    for (int r = 0; r < 8; r++) begin
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
      if (n >= 100) chk_i("out_valid_timeout", n, 0);
      if (r == stall_row) begin
        out_ready = 1'b0;
        held = out_row;
        stable = 1;
        repeat (5) begin
          step();
          if (out_row !== held || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
        end
        chk_i("stall_hold", int'(stable), 1);
        out_ready = 1'b1;
      end
      chk($sformatf("row%0d", r), out_row, q16.pop_front());
      chk($sformatf("sat_row%0d", r), {48'd0, out_row_s}, {48'd0, q10.pop_front()});
      chk($sformatf("last%0d", r), {126'd0, out_last_s, out_last}, {126'd0, {2{qlast.pop_front()}}});
      got[r] = out_row;
      got_s[r] = out_row_s;
      step();
    end
    if (chk_b2b) chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
    else         chk("no_extra_row", {127'd0, out_valid}, 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit leak;
    build_matrix();
    Reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_row = '0;
    repeat (3) step();
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_last", {127'd0, out_last}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_out_row", out_row, 128'd0);
    Reset = 1'b0;

    fill_const(128); send_block(0); collect(-1, 1, 0);

    fill_const(255); send_block(0); collect(-1, 1, 0);
    chk_i("dc_255", int'($signed(got[0][15:0])), 1015);

    fill_const(0); send_block(0); collect(-1, 1, 0);
    chk_i("dc_0", int'($signed(got[0][15:0])), -1024);
    chk_i("dc_0_sat10", int'($signed(got_s[0][9:0])), -512);

    fill_rand(); send_block(0); collect(3, 1, 0);

    fill_rand(); send_block(1); collect(-1, 1, 1);
    fill_rand(); send_block(0); collect(-1, 1, 0);

    fill_const(90); send_block(0);
    repeat (11) step();
    chk("busy_in_col", {127'd0, busy}, 128'd1);
    Reset = 1'b1;
    step();
    chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_in_ready", {127'd0, in_ready}, 128'd0);
    Reset = 1'b0;
    q16.delete();
    q10.delete();
    qlast.delete();
    leak = 0;
    repeat (30) begin
      step();
      if (out_valid !== 1'b0) leak = 1;
    end
    chk_i("no_output_after_abort", int'(leak), 0);
    fill_const(128); send_block(0); collect(-1, 1, 0);

    chk_i("queue_empty", q16.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
